bs_adder: RTL and testbench
===========================

# bs_adder

Bit-serial adder for the BKM datapath. It accepts two N_BITS-wide operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per enabled cycle, using a single full-adder cell and a carry flip-flop. It returns the registered sum and carry-out through a second valid/ready handshake, and sits between the BKM iteration control and the downstream accumulate/normalise stages as the area-optimised alternative to the parallel adder array.

## Interface
- N_BITS, 16, operand and sum width; legal range N_BITS >= 1
- clk  input  1  clock; all state updates on rising edge
- arst_n  input  1  asynchronous reset, active low
- en  input  1  clock enable; when 0 all state is frozen and no handshake transfer occurs
- in_valid  input  1  operands a, b, ci valid
- in_ready  output  1  block can accept operands; in_ready = (state==IDLE) && en
- a  input  N_BITS  summand a, unsigned
- b  input  N_BITS  summand b, unsigned
- ci  input  1  carry in
- out_valid  output  1  result valid; out_valid = (state==DONE) && en
- out_ready  input  1  consumer accepts result
- s  output  N_BITS  sum, registered
- co  output  1  carry out, registered

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On in_valid && in_ready: load a into shift register A and b into shift register B.
  - Set carry register c = ci, clear bit counter cnt = 0, clear the sum shift register, then go to ADD.
- ADD, each en=1 cycle:
  - sum bit = A[0] ^ B[0] ^ c.
  - c <= (A[0]&B[0]) | (A[0]&c) | (B[0]&c).
  - Shift A and B right by one.
  - Shift the sum bit into the sum register MSB, shifting the register right. After N_BITS steps bit i holds result bit i.
  - cnt <= cnt + 1.
- When cnt reaches N_BITS-1 and en=1, the final bit is processed:
  - s <= completed sum register, co <= final carry.
  - Go to DONE.
- cnt width is clog2(N_BITS+1); it never wraps, and it is cleared on every load.
- DONE: s and co are held stable. On out_valid && out_ready, go to IDLE.
- Result identity: {co, s} == a + b + ci, modulo 2^(N_BITS+1). This identity is exact; overflow is impossible.
- in_valid is ignored outside IDLE. Operands are captured once and may change after acceptance.
- en=0 in any state: state, counters, shift registers, s and co are unchanged. in_ready and out_valid read 0.
- N_BITS=1: ADD lasts exactly one enabled cycle.

## Timing
- Reset (arst_n=0, asynchronous):
  - state = IDLE, s = 0, co = 0, cnt = 0, c = 0, out_valid = 0.
  - in_ready = en after reset release.
- Latency: operands accepted on edge k (en continuously 1) → out_valid high after edge k+N_BITS, i.e. N_BITS cycles.
- Each en=0 cycle during ADD adds exactly one cycle of latency.
- Output handshake: the result transfers on the edge where out_valid && out_ready. in_ready rises the following cycle. There is no same-cycle accept-on-drain.
- Throughput with out_ready tied high and en=1: one operation per N_BITS+2 cycles.
- Backpressure: with out_ready low, the block stays in DONE indefinitely, s/co stay stable, and in_ready stays 0.
- Reset asserted mid-ADD or in DONE:
  - The operation is aborted with no output.
  - After reset release the block returns to IDLE and the next operation is fully correct; no residual carry is carried over.
- Simultaneous in_valid and reset: reset wins and nothing is captured.

## Test plan
- N_BITS=16, a=0x1234, b=0x4321, ci=0, out_ready=1, en=1 → s=0x5555, co=0, out_valid exactly 16 cycles after the accept edge, pulse length 1.
- a=0xFFFF, b=0x0000, ci=1 → s=0x0000, co=1. Then a=0xFFFF, b=0xFFFF, ci=1 → s=0xFFFF, co=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → s/co unchanged, in_ready=0 throughout. in_valid pulses in this window are not captured. After out_ready=1, in_ready returns one cycle later.
- en=0 for 3 cycles mid-ADD (a=0x00FF, b=0x0001, ci=0) → s=0x0100, co=0, latency 19 cycles. in_ready and out_valid read 0 while en=0.
- Pull arst_n low 8 cycles into an ADD → out_valid=0, s=0, co=0 immediately. A following operation a=0x0001, b=0x0001, ci=0 gives s=0x0002, co=0.
- Random regression, 10k operations, N_BITS in {1, 8, 16, 33}, random en/out_ready/in_valid gaps → every {co, s} equals a+b+ci. Operation count and order are preserved.

Source files
------------

// File: rtl/bs_adder.sv
// -----------------------------------------------------------------------------
// bs_adder
//
// This is a bit-serial adder for the BKM datapath. It trades adder width for
// latency. The operands are loaded into two shift registers and added LSB-first
// through a single full-adder cell and one carry flip-flop, one bit per enabled
// cycle. The finished sum and carry-out are then held in output registers until
// the consumer takes them.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   arst_n     asynchronous reset, active low
//   en         clock enable; when low every register is frozen and both
//              handshakes read as not-ready / not-valid
//   in_valid   operands a, b, ci are valid
//   in_ready   block is idle and enabled, so operands can be accepted
//   a, b       unsigned summands, N_BITS wide
//   ci         carry in
//   out_valid  s/co hold a finished result and the block is enabled
//   out_ready  consumer accepts the result
//   s          registered sum, N_BITS wide
//   co         registered carry out
// -----------------------------------------------------------------------------
module bs_adder #(
  parameter int N_BITS = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              ci,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] s,
  output logic              co
);

  // The counter must be able to represent N_BITS. It reaches that value on the
  // last step and never wraps before the next load clears it.
  localparam int               CNT_W    = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] aSh_q, aSh_d;
  logic [N_BITS-1:0] bSh_q, bSh_d;
  logic [N_BITS-1:0] sumSh_q, sumSh_d;
  logic              c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] s_q, s_d;
  logic              co_q, co_d;

  logic              sumBit;
  logic              carryNext;
  logic [N_BITS-1:0] sumShifted;

  // The full-adder cell works on the current LSBs of the operand shift
  // registers. The new sum bit enters at the MSB end of the sum shift register.
  // After N_BITS steps the first bit produced has reached bit 0.
  always_comb begin
    sumBit     = aSh_q[0] ^ bSh_q[0] ^ c_q;
    carryNext  = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & c_q) | (bSh_q[0] & c_q);
    sumShifted = sumSh_q >> 1;
    sumShifted[N_BITS-1] = sumBit;
  end

  // Next-state logic. Every register holds its value unless en is high, so a
  // disabled cycle during ADD simply adds one cycle of latency.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aSh_d   = a;
            bSh_d   = b;
            sumSh_d = '0;
            c_d     = ci;
            cnt_d   = '0;
            state_d = ADD;
          end
        end
        ADD: begin
          aSh_d   = aSh_q >> 1;
          bSh_d   = bSh_q >> 1;
          sumSh_d = sumShifted;
          c_d     = carryNext;
          cnt_d   = cnt_q + CNT_W'(1);
          // This step handles the last bit. The result is taken from the
          // shifted value rather than sumSh_q, which still lacks the final bit.
          if (cnt_q == CNT_LAST) begin
            s_d     = sumShifted;
            co_d    = carryNext;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers. Reset aborts any operation in flight and clears the carry,
  // so nothing from an aborted operation reaches the next one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  // Both handshakes are gated by en, so a frozen block never appears to
  // transfer anything.
  assign in_ready  = (state_q == IDLE) && en;
  assign out_valid = (state_q == DONE) && en;
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_bs_adder.sv
// -----------------------------------------------------------------------------
// tb_bs_adder
//
// This bench instantiates four adders with N_BITS of 1, 8, 16 and 33. The
// operand and carry-in buses are shared by all four. Each instance has its own
// en, in_valid and out_ready, so it is only active when selected.
//
// The 16-bit instance runs a table of directed vectors, the backpressure case
// and the reset-abort case. All four instances then run a randomized
// regression. It is checked against the plain arithmetic identity
// {co, s} = a + b + ci, with a queue that keeps the order of operations.
// -----------------------------------------------------------------------------
module tb_bs_adder;

  localparam int NINST = 4;

  logic              clk = 1'b0;
  logic              arst_n;
  logic [32:0]       aW;
  logic [32:0]       bW;
  logic              ci;
  logic [NINST-1:0]  enV;
  logic [NINST-1:0]  inValidV;
  logic [NINST-1:0]  outReadyV;
  logic [NINST-1:0]  inReadyArr;
  logic [NINST-1:0]  outValidArr;
  logic [NINST-1:0]  coArr;
  logic [0:0]        s1;
  logic [7:0]        s8;
  logic [15:0]       s16;
  logic [32:0]       s33;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bs_adder #(.N_BITS(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .en(enV[0]), .in_valid(inValidV[0]),
    .in_ready(inReadyArr[0]), .a(aW[0:0]), .b(bW[0:0]), .ci(ci),
    .out_valid(outValidArr[0]), .out_ready(outReadyV[0]), .s(s1), .co(coArr[0])
  );

  bs_adder #(.N_BITS(8)) dut8 (
    .clk(clk), .arst_n(arst_n), .en(enV[1]), .in_valid(inValidV[1]),
    .in_ready(inReadyArr[1]), .a(aW[7:0]), .b(bW[7:0]), .ci(ci),
    .out_valid(outValidArr[1]), .out_ready(outReadyV[1]), .s(s8), .co(coArr[1])
  );

  bs_adder #(.N_BITS(16)) dut16 (
    .clk(clk), .arst_n(arst_n), .en(enV[2]), .in_valid(inValidV[2]),
    .in_ready(inReadyArr[2]), .a(aW[15:0]), .b(bW[15:0]), .ci(ci),
    .out_valid(outValidArr[2]), .out_ready(outReadyV[2]), .s(s16), .co(coArr[2])
  );

  bs_adder #(.N_BITS(33)) dut33 (
    .clk(clk), .arst_n(arst_n), .en(enV[3]), .in_valid(inValidV[3]),
    .in_ready(inReadyArr[3]), .a(aW), .b(bW), .ci(ci),
    .out_valid(outValidArr[3]), .out_ready(outReadyV[3]), .s(s33), .co(coArr[3])
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    int          gapStart;
    logic [15:0] expS;
    logic        expCo;
    int          expLat;
  } vec_t;

  vec_t vecs[8];

  function automatic int widthOf(input int sel);
    case (sel)
      0:       return 1;
      1:       return 8;
      2:       return 16;
      default: return 33;
    endcase
  endfunction

  function automatic logic [63:0] resultOf(input int sel);
    case (sel)
      0:       return 64'({coArr[0], s1});
      1:       return 64'({coArr[1], s8});
      2:       return 64'({coArr[2], s16});
      default: return 64'({coArr[3], s33});
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // This task presents one operand set to the 16-bit instance and waits for
  // the result. If gapStart is non-zero, en is held low for three cycles,
  // starting gapStart edges after the accept edge. It returns the number of
  // edges from the accept edge until out_valid is seen.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic vci, input int gapStart,
                               output int lat);
    @(negedge clk);
    enV[2]      = 1'b1;
    aW          = {17'b0, va};
    bW          = {17'b0, vb};
    ci          = vci;
    inValidV[2] = 1'b1;
    #1;
    checkOutput("inReady before accept", 64'(inReadyArr[2]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    inValidV[2] = 1'b0;
    aW          = {1'b0, $urandom};
    bW          = {1'b0, $urandom};
    ci          = 1'($urandom_range(0, 1));
    lat         = 0;
    #1;
    while (!outValidArr[2] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      enV[2] = !(gapStart > 0 && lat >= gapStart && lat < gapStart + 3);
      #1;
      if (!enV[2]) begin
        checkOutput("inReady while en=0", 64'(inReadyArr[2]), 64'd0);
        checkOutput("outValid while en=0", 64'(outValidArr[2]), 64'd0);
      end
    end
    if (lat >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL result timeout: got no out_valid, expected one within 200 cycles");
    end
  endtask

  // This task runs a randomized regression on one instance, with random en,
  // in_valid and out_ready activity. Each accepted operation pushes its
  // arithmetic sum into a queue. Each transferred result must match the oldest
  // entry in that queue.
  task automatic runRandom(input int sel, input int nOps);
    logic [63:0] expQ[$];
    logic [63:0] maskS;
    logic [63:0] maskR;
    logic [63:0] rA;
    logic [63:0] rB;
    logic [63:0] rC;
    logic [63:0] expV;
    int          n;
    int          sent;
    int          recv;
    int          cycles;
    int          limit;
    n      = widthOf(sel);
    maskS  = (64'd1 << n) - 64'd1;
    maskR  = (64'd1 << (n + 1)) - 64'd1;
    sent   = 0;
    recv   = 0;
    cycles = 0;
    limit  = nOps * (n + 4) * 4 + 200;
    while (recv < nOps && cycles < limit) begin
      @(negedge clk);
      cycles++;
      rA             = {$urandom, $urandom} & maskS;
      rB             = {$urandom, $urandom} & maskS;
      rC             = 64'($urandom_range(0, 1));
      aW             = rA[32:0];
      bW             = rB[32:0];
      ci             = rC[0];
      enV[sel]       = ($urandom_range(0, 9) != 0);
      outReadyV[sel] = ($urandom_range(0, 3) != 0);
      inValidV[sel]  = (sent < nOps) && ($urandom_range(0, 2) != 0);
      #1;
      if (!enV[sel]) begin
        checkOutput($sformatf("N=%0d handshakes idle while en=0", n),
                    64'({inReadyArr[sel], outValidArr[sel]}), 64'd0);
      end
      if (inValidV[sel] && inReadyArr[sel]) begin
        expQ.push_back((rA + rB + rC) & maskR);
        sent++;
      end
      if (outValidArr[sel] && outReadyV[sel]) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL N=%0d spurious result: got 0x%0h, expected no result", n,
                   resultOf(sel));
        end else begin
          expV = expQ.pop_front();
          checkOutput($sformatf("N=%0d op %0d {co,s}", n, recv), resultOf(sel), expV);
        end
        recv++;
      end
    end
    @(negedge clk);
    enV[sel]       = 1'b0;
    inValidV[sel]  = 1'b0;
    outReadyV[sel] = 1'b0;
    checkOutput($sformatf("N=%0d operations completed", n), 64'(recv), 64'(nOps));
    checkOutput($sformatf("N=%0d operations outstanding", n), 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] heldS;
    logic        heldCo;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 16};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 16};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 16};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 16};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 16};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 16};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 4, 16'h0100, 1'b0, 19};
    vecs[7] = '{16'hAAAA, 16'h5555, 1'b1, 0, 16'h0000, 1'b1, 16};

    arst_n    = 1'b0;
    enV       = '0;
    inValidV  = '0;
    outReadyV = '0;
    aW        = '0;
    bW        = '0;
    ci        = 1'b0;

    // Check the reset state while reset is asserted, then release it.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset s16/co", 64'({coArr[2], s16}), 64'd0);
    checkOutput("reset s33/co", resultOf(3), 64'd0);
    checkOutput("reset outValid", 64'(outValidArr), 64'd0);
    @(negedge clk);
    arst_n       = 1'b1;
    enV[2]       = 1'b1;
    outReadyV[2] = 1'b1;
    #1;
    checkOutput("inReady after reset", 64'(inReadyArr[2]), 64'd1);

    // Run the directed vectors on the 16-bit instance with out_ready tied high.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].gapStart, lat);
      checkOutput($sformatf("vec%0d s", i), 64'(s16), 64'(vecs[i].expS));
      checkOutput($sformatf("vec%0d co", i), 64'(coArr[2]), 64'(vecs[i].expCo));
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d outValid pulse end", i), 64'(outValidArr[2]), 64'd0);
      checkOutput($sformatf("vec%0d inReady after drain", i), 64'(inReadyArr[2]), 64'd1);
    end

    // Backpressure: the result must stay put while out_ready is low, and
    // in_valid pulses during this window must not be captured.
    outReadyV[2] = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 0, lat);
    heldS  = 16'h2345;
    heldCo = 1'b0;
    checkOutput("bp s", 64'(s16), 64'(heldS));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      inValidV[2] = 1'(i % 2);
      aW          = {1'b0, $urandom};
      bW          = {1'b0, $urandom};
      #1;
      checkOutput($sformatf("bp hold %0d {co,s}", i), 64'({coArr[2], s16}),
                  64'({heldCo, heldS}));
      checkOutput($sformatf("bp hold %0d inReady", i), 64'(inReadyArr[2]), 64'd0);
      checkOutput($sformatf("bp hold %0d outValid", i), 64'(outValidArr[2]), 64'd1);
    end
    @(negedge clk);
    inValidV[2]  = 1'b0;
    outReadyV[2] = 1'b1;
    #1;
    checkOutput("bp release outValid", 64'(outValidArr[2]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("bp inReady after drain", 64'(inReadyArr[2]), 64'd1);
    checkOutput("bp outValid after drain", 64'(outValidArr[2]), 64'd0);

    // Reset abort: start an operation, then assert reset 8 cycles into ADD
    // while in_valid is also high.
    @(negedge clk);
    aW          = {17'b0, 16'h0F0F};
    bW          = {17'b0, 16'h0101};
    ci          = 1'b1;
    inValidV[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValidV[2] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    arst_n      = 1'b0;
    inValidV[2] = 1'b1;
    #1;
    checkOutput("abort outValid", 64'(outValidArr[2]), 64'd0);
    checkOutput("abort {co,s}", 64'({coArr[2], s16}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n      = 1'b1;
    inValidV[2] = 1'b0;
    #1;
    checkOutput("inReady after abort", 64'(inReadyArr[2]), 64'd1);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 0, lat);
    checkOutput("post-abort {co,s}", 64'({coArr[2], s16}), 64'h0002);
    checkOutput("post-abort latency", 64'(lat), 64'd16);
    @(posedge clk);
    @(negedge clk);
    enV[2]       = 1'b0;
    outReadyV[2] = 1'b0;

    // Randomized regression on every width.
    for (int sel = 0; sel < NINST; sel++) begin
      runRandom(sel, 400);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
